// File: rtl/gnr_pkg.sv
// Shared definitions for the GRN run controller.
//   - gnr_state_e : controller FSM states
//   - NODES_DEF   : default network size (state-vector width)
//   - STEP_W_DEF  : default width of step counters and limits
package gnr_pkg;

  localparam int NODES_DEF  = 8;
  localparam int STEP_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    PERIOD,
    DONE
  } gnr_state_e;

endpackage

// File: rtl/gnr_cycle_ctrl_if.sv
// Bundle of all run-control and node-bus signals of one network instance.
//   start/init_vec/max_steps : run request from the host
//   busy/done/timeout        : run status back to the host
//   meet_steps/period        : Floyd results
//   reset_nos/init_state     : node (re)load lines
//   start_s0/start_s1        : tortoise / hare step enables
//   s0_vec/s1_vec            : concatenated node outputs (tortoise / hare)
// master : host + network side; slave : the controller.
interface gnr_cycle_ctrl_if import gnr_pkg::*; #(
  parameter int NODES  = NODES_DEF,
  parameter int STEP_W = STEP_W_DEF
);

  logic              start;
  logic [NODES-1:0]  init_vec;
  logic [STEP_W-1:0] max_steps;
  logic [NODES-1:0]  s0_vec;
  logic [NODES-1:0]  s1_vec;

  logic              reset_nos;
  logic [NODES-1:0]  init_state;
  logic              start_s0;
  logic              start_s1;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [STEP_W-1:0] meet_steps;
  logic [STEP_W-1:0] period;

  modport master (
    output start, init_vec, max_steps, s0_vec, s1_vec,
    input  reset_nos, init_state, start_s0, start_s1,
    input  busy, done, timeout, meet_steps, period
  );

  modport slave (
    input  start, init_vec, max_steps, s0_vec, s1_vec,
    output reset_nos, init_state, start_s0, start_s1,
    output busy, done, timeout, meet_steps, period
  );

endinterface

// File: rtl/gnr_step_counter.sv
// Saturating step counter.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count request; ignored once the limit is reached
//   limit      : saturation value
//   cnt        : current count
//   at_limit   : cnt has reached limit
module gnr_step_counter import gnr_pkg::*; #(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [STEP_W-1:0] limit,
  output logic [STEP_W-1:0] cnt,
  output logic              at_limit
);

  // >= rather than == so the flag stays safe even if the limit shrinks.
  assign at_limit = (cnt >= limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_limit) begin
      cnt <= cnt + STEP_W'(1);
    end
  end

endmodule

// File: rtl/gnr_cycle_ctrl.sv
// Per-network run controller: loads the initial state into both node copies,
// then runs Floyd cycle detection (tortoise s0 at half rate, hare s1 at full
// rate), measures the attractor period and reports the result.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : gnr_cycle_ctrl_if.slave (host request/status + node bus)
module gnr_cycle_ctrl import gnr_pkg::*; #(
  parameter int NODES  = NODES_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  gnr_cycle_ctrl_if.slave bus
);

  gnr_state_e        state;
  logic [NODES-1:0]  init_q;
  logic [STEP_W-1:0] lim;
  logic              reset_nos_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [STEP_W-1:0] meet_q;
  logic [STEP_W-1:0] period_q;

  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] per_cnt;
  logic              step_at_lim;
  logic              per_at_lim;

  logic accept;
  logic match;
  logic hit;
  logic phit;
  logic run_pulse;
  logic per_pulse;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign match  = (bus.s0_vec == bus.s1_vec);

  // The tortoise only sits on a whole network step after an even number of
  // hare steps, so meetings are only meaningful there.
  assign hit  = (state == RUN) && !step_cnt[0] && (step_cnt >= STEP_W'(2)) && match;
  assign phit = (state == PERIOD) && (per_cnt != '0) && match;

  // Step enables must react in the same cycle as the comparison of the node
  // outputs, so they are decoded here instead of registered.
  assign run_pulse = (state == RUN) && !hit && !step_at_lim;
  assign per_pulse = (state == PERIOD) && !phit && !per_at_lim;

  assign bus.start_s0   = run_pulse;
  assign bus.start_s1   = run_pulse | per_pulse;
  assign bus.reset_nos  = reset_nos_q;
  assign bus.init_state = init_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.meet_steps = meet_q;
  assign bus.period     = period_q;

  gnr_step_counter #(.STEP_W(STEP_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (run_pulse),
    .limit    (lim),
    .cnt      (step_cnt),
    .at_limit (step_at_lim)
  );

  gnr_step_counter #(.STEP_W(STEP_W)) u_per_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (per_pulse),
    .limit    (lim),
    .cnt      (per_cnt),
    .at_limit (per_at_lim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      init_q      <= '0;
      lim         <= '0;
      reset_nos_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      meet_q      <= '0;
      period_q    <= '0;
    end else begin
      reset_nos_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            init_q      <= bus.init_vec;
            // A zero limit would never let the run start, so it means one step.
            lim         <= (bus.max_steps == '0) ? STEP_W'(1) : bus.max_steps;
            meet_q      <= '0;
            period_q    <= '0;
            timeout_q   <= 1'b0;
            reset_nos_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state       <= INIT;
          end
        end
        INIT: begin
          state <= RUN;
        end
        RUN: begin
          if (hit) begin
            meet_q <= step_cnt;
            state  <= PERIOD;
          end else if (step_at_lim) begin
            meet_q    <= step_cnt;
            timeout_q <= 1'b1;
            period_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        PERIOD: begin
          if (phit) begin
            period_q <= per_cnt;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else if (per_at_lim) begin
            timeout_q <= 1'b1;
            period_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Bench for gnr_cycle_ctrl: a node plant (tortoise/hare copies of a boolean
// network) driven by the DUT, a sequence-level reference model of Floyd
// detection, directed scenarios and randomized networks.
module tb_gnr_cycle_ctrl;

  localparam int NODES  = 8;
  localparam int STEP_W = 16;

  logic clk;
  logic rst;

  gnr_cycle_ctrl_if #(.NODES(NODES), .STEP_W(STEP_W)) bus ();

  gnr_cycle_ctrl #(.NODES(NODES), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- network definition ----------------
  int         mode;            // 0 fixed point, 1 rotate-left, 2 random table
  logic [7:0] tbl [256];

  function automatic logic [7:0] fstep(input logic [7:0] s);
    case (mode)
      0:       return s;
      1:       return {s[6:0], s[7]};
      default: return tbl[s];
    endcase
  endfunction

  function automatic logic [7:0] fpow(input logic [7:0] s, input int n);
    logic [7:0] r = s;
    for (int i = 0; i < n; i++) r = fstep(r);
    return r;
  endfunction

  // ---------------- node plant ----------------
  logic [7:0] n_s0 = 8'h00;
  logic [7:0] n_s1 = 8'h00;
  logic       n_pass = 1'b0;

  always @(posedge clk) begin
    if (bus.reset_nos) begin
      n_s0   <= bus.init_state;
      n_s1   <= bus.init_state;
      n_pass <= 1'b1;
    end else begin
      if (bus.start_s1) n_s1 <= fstep(n_s1);
      if (bus.start_s0) begin
        if (n_pass) n_pass <= 1'b0;
        else begin
          n_s0   <= fstep(n_s0);
          n_pass <= 1'b1;
        end
      end
    end
  end

  assign bus.s0_vec = n_s0;
  assign bus.s1_vec = n_s1;

  // ---------------- reference model ----------------
  int         exp_meet, exp_per, exp_to, exp_s1p, exp_s0p, exp_busy;
  logic [7:0] exp_init;
  bit         exp_armed = 1'b0;

  // Floyd on the explicit state sequence x, f(x), f^2(x), ...
  task automatic model(input logic [7:0] x, input int mx);
    int lim = (mx == 0) ? 1 : mx;
    int meet = 0;
    int p = 0;
    logic [7:0] t;
    for (int k = 2; k <= lim; k += 2) begin
      if (fpow(x, k / 2) == fpow(x, k)) begin
        meet = k;
        break;
      end
    end
    if (meet == 0) begin
      exp_meet = lim; exp_to = 1; exp_per = 0;
      exp_s1p = lim; exp_s0p = lim; exp_busy = 1 + lim + 1;
    end else begin
      t = fpow(x, meet / 2);
      for (int q = 1; q <= lim; q++) begin
        if (fpow(t, q) == t) begin
          p = q;
          break;
        end
      end
      exp_meet = meet; exp_s0p = meet;
      if (p != 0) begin
        exp_per = p; exp_to = 0;
        exp_s1p = meet + p; exp_busy = 1 + (meet + 1) + (p + 1);
      end else begin
        exp_per = 0; exp_to = 1;
        exp_s1p = meet + lim; exp_busy = 1 + (meet + 1) + (lim + 1);
      end
    end
  endtask

  // ---------------- monitor / compare ----------------
  int s1_cnt = 0, s0_cnt = 0, rn_cnt = 0, busy_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.start_s1)  s1_cnt   <= s1_cnt + 1;
      if (bus.start_s0)  s0_cnt   <= s0_cnt + 1;
      if (bus.reset_nos) rn_cnt   <= rn_cnt + 1;
      if (bus.busy)      busy_cyc <= busy_cyc + 1;
      check("pulse_with_reset_nos", int'(bus.reset_nos & (bus.start_s0 | bus.start_s1)), 0);
      check("s0_without_s1", int'(bus.start_s0 & ~bus.start_s1), 0);
      if (exp_armed) begin
        check("busy_xor_done", int'(bus.busy ^ bus.done), 1);
        check("init_state", int'(bus.init_state), int'(exp_init));
        if (bus.done) begin
          check("timeout", int'(bus.timeout), exp_to);
          check("meet_steps", int'(bus.meet_steps), exp_meet);
          check("period", int'(bus.period), exp_per);
        end
      end
    end
  end

  // ---------------- driver ----------------
  int b_s1, b_s0, b_rn, b_busy;

  task automatic pulse_start(input logic [7:0] x, input int mx);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.init_vec  = x;
    bus.max_steps = STEP_W'(mx);
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic start_case(input int m, input logic [7:0] x, input int mx);
    exp_armed = 1'b0;
    mode      = m;
    model(x, mx);
    exp_init  = x;
    b_s1 = s1_cnt; b_s0 = s0_cnt; b_rn = rn_cnt; b_busy = busy_cyc;
    pulse_start(x, mx);
    exp_armed = 1'b1;
  endtask

  task automatic finish_case(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, "_s1_pulses"}, s1_cnt - b_s1, exp_s1p);
      check({tag, "_s0_pulses"}, s0_cnt - b_s0, exp_s0p);
      check({tag, "_reset_nos_cycles"}, rn_cnt - b_rn, 1);
      check({tag, "_busy_cycles"}, busy_cyc - b_busy, exp_busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reset_nos"}, int'(bus.reset_nos), 0);
    check({tag, "_start_s0"}, int'(bus.start_s0), 0);
    check({tag, "_start_s1"}, int'(bus.start_s1), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
    check({tag, "_meet"}, int'(bus.meet_steps), 0);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_init_state"}, int'(bus.init_state), 0);
  endtask

  initial begin
    bit  seen;
    int  mx;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.init_vec  = '0;
    bus.max_steps = '0;
    mode          = 0;
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Fixed point.
    start_case(0, 8'h5A, 100);
    finish_case("fixed");
    check("fixed_meet_lit", int'(bus.meet_steps), 2);
    check("fixed_period_lit", int'(bus.period), 1);
    check("fixed_timeout_lit", int'(bus.timeout), 0);
    check("fixed_busy_lit", busy_cyc - b_busy, 6);

    // Rotate-left network, period 8.
    start_case(1, 8'h01, 100);
    finish_case("rot");
    check("rot_meet_lit", int'(bus.meet_steps), 16);
    check("rot_period_lit", int'(bus.period), 8);
    check("rot_timeout_lit", int'(bus.timeout), 0);

    // Rotate with a step limit too short to meet.
    start_case(1, 8'h01, 10);
    finish_case("rot_lim");
    check("rot_lim_pulses_lit", s1_cnt - b_s1, 10);
    check("rot_lim_timeout_lit", int'(bus.timeout), 1);
    check("rot_lim_period_lit", int'(bus.period), 0);
    check("rot_lim_meet_lit", int'(bus.meet_steps), 10);

    // Start while busy is ignored, then restart from DONE.
    start_case(1, 8'h01, 100);
    repeat (5) @(posedge clk);
    pulse_start(8'h03, 5);
    finish_case("rot_ignore");
    check("rot_ignore_meet_lit", int'(bus.meet_steps), 16);
    check("rot_ignore_period_lit", int'(bus.period), 8);
    start_case(1, 8'h00, 100);
    finish_case("rot_zero");
    check("rot_zero_meet_lit", int'(bus.meet_steps), 2);
    check("rot_zero_period_lit", int'(bus.period), 1);

    // Reset in the middle of the period measurement.
    start_case(1, 8'h01, 100);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (s1_cnt - b_s1 >= 19) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_period_phase", int'(seen), 1);
    check("in_period_s0_frozen", int'(bus.start_s0), 0);
    exp_armed = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    @(posedge clk); #1 check_all_zero("mid_reset_held");
    @(posedge clk); #1 rst = 1'b1;
    start_case(0, 8'hC3, 100);
    finish_case("after_reset");

    // Random networks, including a zero step limit.
    mode = 2;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom_range(0, 255));
      if (r == 0)          mx = 0;
      else if (r % 3 == 0) mx = int'($urandom_range(1, 12));
      else                 mx = int'($urandom_range(20, 80));
      start_case(2, 8'($urandom_range(0, 255)), mx);
      finish_case("rand");
    end

    exp_armed = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
